dsi_packet_assembler: RTL

Builds MIPI DSI packets and drives them, one 32-bit word at a time, into the word interface of `dsi_lanes_controller`. It accepts a packet command (data ID, word count, short/long) plus a 32-bit payload stream, prepends the 4-byte header with ECC, appends the CRC-16 to long packets and packs everything byte-exactly with strobes. It sits between the video/command packetizer and the lanes controller in the `clk_sys` domain, acting as the data source for `iface_data_rqst`.

---
 rtl/dsi_packet_assembler_pkg.sv | 37 +++
 rtl/dsi_packet_assembler_if.sv | 19 +
 rtl/dsi_crc16_word.sv | 20 ++
 rtl/dsi_packet_assembler.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/dsi_packet_assembler_pkg.sv
// Shared types and arithmetic for the DSI packet assembler: FSM states,
// header ECC and the byte-serial CRC-16 used on long-packet payloads.
package dsi_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_HEADER,
      ST_PAYLOAD,
      ST_CRC_TAIL
   } dsi_state_t;

   localparam logic [15:0] CRC_SEED = 16'hFFFF;
   localparam logic [15:0] CRC_POLY = 16'h8408;

   // Hamming parity over {WC, DI}; bit 0 of d is DI[0]. Upper two bits stay zero.
   function automatic logic [7:0] dsi_ecc(input logic [23:0] d);
      logic [7:0] e;
      e    = 8'h00;
      e[0] = d[0]^d[1]^d[2]^d[4]^d[5]^d[7]^d[10]^d[11]^d[13]^d[16]^d[20]^d[21]^d[22]^d[23];
      e[1] = d[0]^d[1]^d[3]^d[4]^d[6]^d[8]^d[10]^d[12]^d[14]^d[17]^d[20]^d[21]^d[22]^d[23];
      e[2] = d[0]^d[2]^d[3]^d[5]^d[6]^d[9]^d[11]^d[12]^d[15]^d[18]^d[20]^d[21]^d[22];
      e[3] = d[1]^d[2]^d[3]^d[7]^d[8]^d[9]^d[13]^d[14]^d[15]^d[19]^d[20]^d[21]^d[23];
      e[4] = d[4]^d[5]^d[6]^d[7]^d[8]^d[9]^d[16]^d[17]^d[18]^d[19]^d[20]^d[22]^d[23];
      e[5] = d[10]^d[11]^d[12]^d[13]^d[14]^d[15]^d[16]^d[17]^d[18]^d[19]^d[21]^d[22]^d[23];
      return e;
   endfunction

   function automatic logic [15:0] dsi_crc16_byte(input logic [15:0] crc, input logic [7:0] data);
      logic [15:0] c;
      c = crc ^ {8'h00, data};
      for (int i = 0; i < 8; i++) begin
         c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
      end
      return c;
   endfunction

endpackage

// File: rtl/dsi_packet_assembler_if.sv
// Word interface between the packet assembler (master) and the lanes
// controller (slave); data_rqst is the controller's consume strobe.
interface dsi_packet_assembler_if;
   logic [31:0] write_data;
   logic [3:0]  write_strb;
   logic        write_rqst;
   logic        last_word;
   logic        data_rqst;

   modport master (
      output write_data, write_strb, write_rqst, last_word,
      input  data_rqst
   );

   modport slave (
      input  write_data, write_strb, write_rqst, last_word,
      output data_rqst
   );
endinterface

// File: rtl/dsi_crc16_word.sv
// Folds up to four bytes of a payload word into the running CRC-16,
// byte 0 first, skipping bytes whose enable is low.
module dsi_crc16_word
   import dsi_pkg::*;
(
   input  logic [15:0] crc_in,
   input  logic [31:0] data,
   input  logic [3:0]  byte_en,
   output logic [15:0] crc_out
);
   logic [15:0] c;

   always_comb begin
      c = crc_in;
      for (int i = 0; i < 4; i++) begin
         if (byte_en[i]) c = dsi_crc16_byte(c, data[8*i +: 8]);
      end
      crc_out = c;
   end
endmodule

// File: rtl/dsi_packet_assembler.sv
// Assembles DSI short/long packets (header+ECC, payload, CRC-16) into
// byte-exact 32-bit words for the lanes controller.
module dsi_packet_assembler
   import dsi_pkg::*;
(
   input  logic                   clk_sys,
   input  logic                   rst_n,
   input  logic                   cmd_valid,
   output logic                   cmd_ready,
   input  logic [7:0]             cmd_data_id,
   input  logic [15:0]            cmd_word_count,
   input  logic                   cmd_long,
   input  logic [31:0]            pld_data,
   input  logic                   pld_valid,
   output logic                   pld_ready,
   output logic                   busy,
   output logic                   pld_underflow,
   dsi_packet_assembler_if.master iface
);
   dsi_state_t  state;
   logic [31:0] out_data;
   logic [3:0]  out_strb;
   logic        out_rqst;
   logic        out_last;
   logic [15:0] crc;
   logic [15:0] crc_next;
   logic [15:0] remaining;
   logic [1:0]  wc_lsb;
   logic [3:0]  load_mask;
   logic [15:0] load_count;
   logic [31:0] load_data;
   logic [3:0]  load_strb;
   logic        load_last;
   logic        consume;
   logic        needs_payload;
   logic        payload_retry;

   assign iface.write_data = out_data;
   assign iface.write_strb = out_strb;
   assign iface.write_rqst = out_rqst;
   assign iface.last_word  = out_last;

   assign consume       = out_rqst & iface.data_rqst;
   assign needs_payload = ((state == ST_HEADER) || (state == ST_PAYLOAD)) && (remaining != 16'd0);
   assign payload_retry = (state == ST_PAYLOAD) && !out_rqst;
   assign pld_ready     = (consume | payload_retry) & needs_payload & pld_valid;
   assign cmd_ready     = (state == ST_IDLE);
   assign busy          = (state != ST_IDLE);

   dsi_crc16_word u_crc (
      .crc_in  (crc),
      .data    (pld_data),
      .byte_en (load_mask),
      .crc_out (crc_next)
   );

   // The final 1..3 payload bytes share their word with the leading CRC bytes.
   always_comb begin
      load_mask  = 4'hF;
      load_count = 16'd4;
      load_data  = pld_data;
      load_strb  = 4'hF;
      load_last  = 1'b0;
      case (remaining)
         16'd1: begin
            load_mask  = 4'h1;
            load_count = 16'd1;
            load_data  = {8'h00, crc_next, pld_data[7:0]};
            load_strb  = 4'h7;
            load_last  = 1'b1;
         end
         16'd2: begin
            load_mask  = 4'h3;
            load_count = 16'd2;
            load_data  = {crc_next, pld_data[15:0]};
            load_last  = 1'b1;
         end
         16'd3: begin
            load_mask  = 4'h7;
            load_count = 16'd3;
            load_data  = {crc_next[7:0], pld_data[23:0]};
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk_sys or negedge rst_n) begin
      if (!rst_n) begin
         state         <= ST_IDLE;
         out_data      <= 32'h0;
         out_strb      <= 4'h0;
         out_rqst      <= 1'b0;
         out_last      <= 1'b0;
         crc           <= CRC_SEED;
         remaining     <= 16'd0;
         wc_lsb        <= 2'b00;
         pld_underflow <= 1'b0;
      end else begin
         pld_underflow <= 1'b0;
         if (state == ST_IDLE) begin
            if (cmd_valid) begin
               state     <= ST_HEADER;
               out_data  <= {dsi_ecc({cmd_word_count, cmd_data_id}), cmd_word_count, cmd_data_id};
               out_strb  <= 4'hF;
               out_rqst  <= 1'b1;
               out_last  <= !cmd_long;
               crc       <= CRC_SEED;
               remaining <= cmd_long ? cmd_word_count : 16'd0;
               wc_lsb    <= cmd_word_count[1:0];
            end
         end else if (consume && out_last) begin
            state    <= ST_IDLE;
            out_data <= 32'h0;
            out_strb <= 4'h0;
            out_rqst <= 1'b0;
            out_last <= 1'b0;
         end else if (needs_payload && (consume || payload_retry)) begin
            if (pld_valid) begin
               state     <= ST_PAYLOAD;
               out_data  <= load_data;
               out_strb  <= load_strb;
               out_rqst  <= 1'b1;
               out_last  <= load_last;
               crc       <= crc_next;
               remaining <= remaining - load_count;
            end else if (consume) begin
               state         <= ST_PAYLOAD;
               out_rqst      <= 1'b0;
               pld_underflow <= 1'b1;
            end
         end else if (consume) begin
            // Payload exhausted without its CRC fully sent: emit the tail word.
            state    <= ST_CRC_TAIL;
            out_last <= 1'b1;
            if (wc_lsb == 2'b11) begin
               out_data <= {24'h0, crc[15:8]};
               out_strb <= 4'h1;
            end else begin
               out_data <= {16'h0, crc};
               out_strb <= 4'h3;
            end
         end
      end
   end
endmodule
